pc_sequencer: RTL

- Program-counter and fetch sequencer for the RV32I core.
- Consumes the `branch` decision from the branch comparison unit, together with the decoded control-transfer type from the execute stage.
- Computes the next PC, drives the instruction-memory request handshake and issues pipeline flushes on taken transfers.
- Traps on misaligned targets.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_target_calc.sv | 28 ++
 rtl/pc_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared constants for the PC sequencer: datapath width, reset vector and FSM state encodings.
package pc_sequencer_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    localparam logic [1:0] ST_RESET         = 2'd0;
    localparam logic [1:0] ST_FETCH         = 2'd1;
    localparam logic [1:0] ST_REDIRECT_WAIT = 2'd2;
    localparam logic [1:0] ST_TRAP          = 2'd3;

    typedef enum logic [1:0] {
        RESET         = ST_RESET,
        FETCH         = ST_FETCH,
        REDIRECT_WAIT = ST_REDIRECT_WAIT,
        TRAP          = ST_TRAP
    } seq_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Control-transfer target, link address and misalignment detection for the execute-stage instruction.
module pc_target_calc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            branch,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] link_addr,
    output logic            taken,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = ex_rs1 + ex_imm;

    // JALR wins over JAL/branch; JAL and branch share the PC-relative target.
    assign target     = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    assign taken      = ex_is_jalr | ex_is_jal | (ex_is_branch & branch);
    assign misaligned = |target[1:0];
    assign link_addr  = ex_pc + XLEN'(4);

endmodule

// File: rtl/pc_sequencer.sv
// RV32I program-counter / fetch sequencer with redirect, flush and misaligned-target trap.
// Optional PC_SEQ_STATS_EN adds stat_taken / stat_flush event counters.
module pc_sequencer #(
    parameter int              XLEN         = pc_sequencer_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = pc_sequencer_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            branch,
    output logic            flush,
    output logic [XLEN-1:0] link_addr,
`ifdef PC_SEQ_STATS_EN
    output logic [31:0]     stat_taken,
    output logic [31:0]     stat_flush,
`endif
    output logic            trap,
    output logic [XLEN-1:0] trap_addr
);

    import pc_sequencer_pkg::*;

    seq_state_e      state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] trap_addr_q;
    logic            req_q;
    logic            trap_q;

    logic [XLEN-1:0] target;
    logic            xfer_taken;
    logic            misaligned;
    logic            active;
    logic            redirect;
    logic            redirect_ok;
    logic            redirect_bad;

    pc_target_calc #(.XLEN(XLEN)) u_target_calc (
        .ex_pc        (ex_pc),
        .ex_is_branch (ex_is_branch),
        .ex_is_jal    (ex_is_jal),
        .ex_is_jalr   (ex_is_jalr),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .branch       (branch),
        .target       (target),
        .link_addr    (link_addr),
        .taken        (xfer_taken),
        .misaligned   (misaligned)
    );

    // Redirects are only honoured while fetching; a reset cycle masks everything.
    assign active       = (state == FETCH) || (state == REDIRECT_WAIT);
    assign redirect     = rst_n & active & ex_valid & ~stall & xfer_taken;
    assign redirect_ok  = redirect & ~misaligned;
    assign redirect_bad = redirect & misaligned;
    assign flush        = redirect | (rst_n & (state == REDIRECT_WAIT) & imem_ack);

    assign imem_req  = req_q;
    assign imem_addr = pc;
    assign trap      = trap_q;
    assign trap_addr = trap_addr_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RESET;
            pc          <= RESET_VECTOR;
            pend_pc     <= '0;
            req_q       <= 1'b0;
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            unique case (state)
                RESET: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH, REDIRECT_WAIT: begin
                    if (redirect_bad) begin
                        state       <= TRAP;
                        req_q       <= 1'b0;
                        trap_q      <= 1'b1;
                        trap_addr_q <= target;
                    end else if (state == FETCH) begin
                        if (redirect_ok && imem_ack) begin
                            pc <= target;
                        end else if (redirect_ok) begin
                            pend_pc <= target;
                            state   <= REDIRECT_WAIT;
                        end else if (imem_ack && !stall) begin
                            pc <= pc + XLEN'(4);
                        end
                    end else if (imem_ack) begin
                        // Outstanding response is discarded; the latest target wins.
                        pc    <= redirect_ok ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect_ok) begin
                        pend_pc <= target;
                    end
                end
                TRAP: begin
                    state <= TRAP;
                end
            endcase
        end
    end

`ifdef PC_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_taken <= '0;
            stat_flush <= '0;
        end else begin
            stat_taken <= stat_taken + 32'(redirect_ok);
            stat_flush <= stat_flush + 32'(flush);
        end
    end
`endif

endmodule
